if_fetch_stage: RTL
===================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the MIPS32 pipeline. Directly upstream of id_ex: supplies id_pc/id_inst.
//  Owns the PC and issues word requests to instruction memory. Buffers returned words in a small
//  in-order queue and presents them to decode under a valid/ready handshake.
//  A branch/jump redirect from the execute stage flushes the queue and discards in-flight responses.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC of the first fetch after reset (bits[1:0] must be 0)
//  Q_DEPTH    2              fetch queue entries; power of two, >=2; also the max in-flight+queued count
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   reset, asynchronous, active-low
//  imem_req       out  1   request valid to instruction memory
//  imem_addr      out  32  word address of request; bits[1:0] always 2'b00
//  imem_ready     in   1   memory accepts request this cycle (transfer = imem_req & imem_ready)
//  imem_rvalid    in   1   response valid; responses return in request order, latency >=1 cycle
//  imem_rdata     in   32  response instruction word
//  redirect_valid in   1   execute-stage branch/jump taken; one-cycle pulse
//  redirect_pc    in   32  new fetch PC; bits[1:0] ignored (treated as 00)
//  id_ready       in   1   decode can accept an instruction this cycle (low = stall)
//  id_valid       out  1   id_pc/id_inst hold a valid instruction
//  id_pc          out  32  address of the presented instruction
//  id_inst        out  32  presented instruction; 32'h0 (NOP) whenever id_valid=0
// BEHAVIOUR
//  Reset (rst=0, async): pc<=RESET_PC, queue empty, outstanding=0, discard=0, state<=BOOT;
//   imem_req=0, id_valid=0, id_pc=0, id_inst=0.
//  FSM: BOOT -> RUN unconditionally on first clk edge after reset release. BOOT issues nothing.
//   RUN is the only state left afterwards. Reset is the only way back to BOOT.
//  Counters (width clog2(Q_DEPTH)+1): count = queue occupancy;
//   outstanding = accepted requests not yet answered;
//   discard = responses still to be dropped (subset of outstanding).
//  Issue rule (RUN, redirect_valid=0): imem_req = (count + outstanding - pop) < Q_DEPTH,
//   where pop = id_valid & id_ready. imem_addr = pc. A transfer advances pc <= pc + 4 (wraps mod 2^32).
//   Guarantees every response has a free queue slot; no response is ever dropped for lack of space.
//  imem_req is held with stable imem_addr until imem_ready, unless a redirect intervenes.
//  Response: imem_rvalid with discard>0 -> discard-=1, word dropped. Otherwise push {pc_tag, imem_rdata};
//   the per-request PC is tracked in a Q_DEPTH-entry tag FIFO written on transfer.
//   imem_rvalid with outstanding=0 is a protocol error: ignored, no state change.
//  Decode side: id_valid = (count != 0); id_pc/id_inst = queue head. pop removes the head.
//   Zero-bubble: with memory latency 1 and id_ready=1, one instruction per cycle is sustained.
//  Push and pop in the same cycle: both take effect; count unchanged.
//  Redirect (redirect_valid=1 at an edge), highest priority:
//   - queue and tag FIFO flushed (count<=0); a same-cycle pop or push is void.
//   - discard <= outstanding' (all in-flight requests, including a transfer in this same cycle,
//     minus any non-discarded response consumed this cycle).
//   - pc <= {redirect_pc[31:2],2'b00}; imem_req forced 0 this cycle; new fetch issues next cycle.
//   - redirect during BOOT is ignored (pc stays RESET_PC).
//  Back-to-back redirects: each restarts from its redirect_pc; discard accumulates correctly.
//  Asserting rst mid-transfer abandons all state; memory side must also reset.
// TESTING
//  1 Reset then RUN, imem latency 1, ready=1, id_ready=1 -> imem_addr 0,4,8,... one per cycle;
//    id_pc 0,4,8 on consecutive cycles after 2-cycle startup; id_inst matches memory.
//  2 id_ready=0 for 10 cycles -> at most Q_DEPTH(2) requests issued, id_valid=1 and id_pc=0 held stable;
//    on release, id_pc 0,4,8 with no gaps and no lost/duplicated word.
//  3 imem latency 3, redirect_pc=32'h0000_0100 while 2 requests in flight ->
//    both stale responses dropped; next id_pc=0x100, then 0x104.
//  4 Redirect in same cycle as a pop and a response push -> queue empty next cycle,
//    id_valid=0, imem_addr=0x100 the following cycle.
//  5 redirect_pc=32'hFFFF_FFFE -> fetch 0xFFFF_FFFC then 0x0000_0000 (low bits masked, PC wraps).
//  6 rst pulsed low mid-stream with id_valid=1 -> id_valid=0, imem_req=0 immediately (async);
//    restart fetches RESET_PC.

Source files
------------

// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect from execute, decode handshake.
// The fetch stage uses modport master; the memory/pipeline environment uses slave.
interface if_fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    modport master (
        output imem_req, imem_addr, id_valid, id_pc, id_inst,
        input  imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );

    modport slave (
        input  imem_req, imem_addr, id_valid, id_pc, id_inst,
        output imem_ready, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, id_ready
    );
endinterface

// File: rtl/if_fetch_stage.sv
// MIPS32 instruction-fetch stage: owns the PC, issues word fetches, queues in-order responses
// and hands them to decode; a redirect flushes the queue and drops responses still in flight.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned Q_DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    if_fetch_stage_if.master  bus
);
    localparam int unsigned PW = $clog2(Q_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW:0] DEPTH_L = (CW + 1)'(Q_DEPTH);

    typedef enum logic [0:0] {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t          state_r, state_s;
    logic [31:0]     pc_r;
    logic [CW-1:0]   count_r, outstanding_r, discard_r;
    logic [PW-1:0]   q_wr_r, q_rd_r, tag_wr_r, tag_rd_r;
    logic [31:0]     q_pc_r   [Q_DEPTH];
    logic [31:0]     q_inst_r [Q_DEPTH];
    logic [31:0]     tag_r    [Q_DEPTH];

    logic            run_s, flush_s, pop_s, req_s, xfer_s, rsp_s, drop_s, push_s, valid_s;
    logic [CW:0]     occ_s;
    logic [CW-1:0]   out_next_s;

    // Next-state logic: BOOT lasts exactly one cycle after reset release.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_BOOT: state_s = ST_RUN;
            ST_RUN:  state_s = ST_RUN;
            default: state_s = ST_BOOT;
        endcase
    end

    // Handshake decode; occupancy counts in-flight requests so every response is guaranteed a slot.
    always_comb begin
        run_s      = (state_r == ST_RUN);
        flush_s    = run_s & bus.redirect_valid;
        valid_s    = (count_r != '0);
        pop_s      = valid_s & bus.id_ready;
        occ_s      = {1'b0, count_r} + {1'b0, outstanding_r} - (CW + 1)'(pop_s);
        req_s      = run_s & ~bus.redirect_valid & (occ_s < DEPTH_L);
        xfer_s     = req_s & bus.imem_ready;
        rsp_s      = bus.imem_rvalid & (outstanding_r != '0);
        drop_s     = rsp_s & (discard_r != '0);
        push_s     = rsp_s & ~drop_s;
        out_next_s = outstanding_r + CW'(xfer_s) - CW'(rsp_s);
    end

    // Output drive; decode sees a NOP and zero PC whenever nothing is valid.
    always_comb begin
        bus.imem_req  = req_s;
        bus.imem_addr = pc_r;
        bus.id_valid  = valid_s;
        if (valid_s) begin
            bus.id_pc   = q_pc_r[q_rd_r];
            bus.id_inst = q_inst_r[q_rd_r];
        end else begin
            bus.id_pc   = 32'h0000_0000;
            bus.id_inst = 32'h0000_0000;
        end
    end

    // State, PC, counters and queue pointers; a redirect turns everything in flight into discards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= ST_BOOT;
            pc_r          <= RESET_PC;
            count_r       <= '0;
            outstanding_r <= '0;
            discard_r     <= '0;
            q_wr_r        <= '0;
            q_rd_r        <= '0;
            tag_wr_r      <= '0;
            tag_rd_r      <= '0;
        end else begin
            state_r       <= state_s;
            outstanding_r <= out_next_s;
            if (flush_s) begin
                pc_r      <= bus.redirect_pc & 32'hFFFF_FFFC;
                count_r   <= '0;
                discard_r <= out_next_s;
                q_wr_r    <= '0;
                q_rd_r    <= '0;
                tag_wr_r  <= '0;
                tag_rd_r  <= '0;
            end else begin
                if (xfer_s) begin
                    pc_r <= pc_r + 32'd4;
                end
                count_r   <= count_r + CW'(push_s) - CW'(pop_s);
                discard_r <= discard_r - CW'(drop_s);
                q_wr_r    <= q_wr_r + PW'(push_s);
                q_rd_r    <= q_rd_r + PW'(pop_s);
                tag_wr_r  <= tag_wr_r + PW'(xfer_s);
                tag_rd_r  <= tag_rd_r + PW'(push_s);
            end
        end
    end

    // Payload storage: request PCs are tagged on transfer and paired with their word on response.
    always_ff @(posedge clk) begin
        if (push_s && !flush_s) begin
            q_pc_r[q_wr_r]   <= tag_r[tag_rd_r];
            q_inst_r[q_wr_r] <= bus.imem_rdata;
        end
        if (xfer_s) begin
            tag_r[tag_wr_r] <= pc_r;
        end
    end
endmodule
